ram_unaligned_banked_pipe: RTL and testbench
============================================

Name: ram_unaligned_banked_pipe

Overview:
Single-port byte-addressable RAM built from LANES byte-wide synchronous sub-RAM banks. It accepts unaligned LANES-byte reads and writes at any byte address; an access may cross a row boundary. Requests use a valid/ready handshake and read responses use a valid/ready handshake. It replaces the fixed 16-lane unaligned RAM for vector load/store paths that need configurable width, an optional output register and response backpressure.

Parameters:
LANES, 16, byte lanes (banks) per row; power of two, 2..64
ADDR_W, 20, byte address width; ROW_W = ADDR_W - log2(LANES)
OUT_REG, 1, 0 or 1; adds one register stage after the bank outputs
FIFO_DEPTH, 2+OUT_REG, response FIFO entries; must be at least 1+OUT_REG+1
INIT_FILE, "", per-bank init file path; empty means contents are undefined

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_address  in  ADDR_W  byte address (any alignment)
req_data  in  8*LANES  write data, byte i goes to address+i
req_byte_en  in  LANES  per-byte write enable, bit i for address+i
resp_valid  out  1  read data available
resp_ready  in  1  consumer takes the response when resp_valid && resp_ready
resp_data  out  8*LANES  read data, byte i from address+i

Behaviour:
- Address split: off = req_address[log2(LANES)-1:0]; row = upper ROW_W bits.
- Bank i is accessed at row+1 if i < off, otherwise at row. The +1 wraps modulo 2^ROW_W, so the top-of-memory access wraps to row 0.
- Write path:
  - Data is rotated left by off bytes (circular).
  - req_byte_en is rotated left by off bits (circular, no bits dropped).
  - Bank write enables = rotated enables AND (req_valid && req_ready && req_write).
  - Memory is updated at the accepting edge. A read accepted in the next cycle sees the new data.
- Read path:
  - Banks are read at the accepting edge. off is captured into a pipeline that tracks the data, so rotation never uses the live address.
  - Bank data is valid 1 cycle after acceptance. If OUT_REG=1 it is registered one more cycle.
  - The aligned data is rotated right by the captured off and pushed into the response FIFO.
  - Read latency (accept edge to resp_valid, FIFO empty, resp_ready=1) is 1+OUT_REG cycles.
- Response FIFO:
  - First-word-fall-through, depth FIFO_DEPTH; responses leave in request order.
  - resp_data is only meaningful while resp_valid=1.
  - A pop and a push in the same cycle keep the count unchanged.
- Credit control:
  - outstanding = reads in the pipeline + FIFO count.
  - req_ready = (outstanding < FIFO_DEPTH). This applies to writes too; writes never create responses.
  - The FIFO can never overflow.
  - In the same cycle, a read accept raises outstanding by 1 and a pop lowers it by 1; together they leave it unchanged.
- Reset (reset=0, asynchronous):
  - In-flight reads and FIFO contents are discarded; outstanding=0.
  - resp_valid=0; req_ready=1 one cycle after reset deasserts and 0 while reset is asserted.
  - resp_data resets to 0.
  - Bank contents are not reset.
  - A write accepted at the edge reset asserts is not guaranteed.
- req_byte_en is ignored on reads; resp_data is always the full LANES bytes.

Test Plan:
- Aligned write/read (LANES=16, OUT_REG=1): write address 0x00020, data byte i = i, enables 0xFFFF; read 0x00020 -> resp_valid exactly 2 cycles after the read is accepted, resp_data bytes 0x00..0x0F.
- Unaligned row crossing: write address 0x0000D with byte i = 0xA0+i, full enables; read 0x0000D -> bytes 0xA0..0xAF. Read 0x00010 -> bytes 0..12 = 0xA3..0xAF.
- Partial enables: write 0x00005, enables 0x0003, data bytes 0x11,0x22 -> only addresses 5 and 6 change. A read of 0x00005 shows 0x11,0x22 followed by the previous contents.
- Top wrap: write 0xFFFFA, full enables -> bytes 6..15 land at row 0 lanes 0..9. Reading 0x00000 returns them in bytes 0..9.
- Backpressure: resp_ready=0, issue 5 back-to-back reads of distinct addresses -> req_ready drops after FIFO_DEPTH (3) accepts. Raise resp_ready -> the 3 responses come out in order, then the remaining reads are accepted; no loss or duplication.
- Reset mid-flight: 2 reads accepted, then reset low for 1 cycle -> resp_valid=0 immediately and stays 0; outstanding=0. Memory written before reset reads back unchanged afterwards.

Source files
------------

// File: rtl/ram_unaligned_banked_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_unaligned_banked_pipe
// Purpose  : Single-port byte-addressable RAM made of LANES byte-wide
//            synchronous banks. Accepts LANES-byte reads and writes at any
//            byte address, including accesses that cross a row boundary or
//            wrap from the top of memory to row 0. Read responses pass
//            through a first-word-fall-through FIFO. Requests are only
//            accepted while a FIFO slot is reserved for them, so response
//            backpressure can never overflow the FIFO.
// Ports    : clock       - rising-edge clock
//            reset       - asynchronous active-low reset
//            req_valid   - request present
//            req_ready   - request accepted when req_valid && req_ready
//            req_write   - 1 = write, 0 = read
//            req_address - byte address, any alignment
//            req_data    - write data, byte i goes to address+i
//            req_byte_en - per-byte write enable, bit i for address+i
//            resp_valid  - read data available
//            resp_ready  - response consumed when resp_valid && resp_ready
//            resp_data   - read data, byte i from address+i (0 when idle)
// Revision : 1.0 - initial release
// ============================================================================
module ram_unaligned_banked_pipe #(
   parameter int    LANES      = 16,
   parameter int    ADDR_W     = 20,
   parameter int    OUT_REG    = 1,
   parameter int    FIFO_DEPTH = 2 + OUT_REG,
   parameter string INIT_FILE  = ""
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_W-1:0]    req_address,
   input  logic [8*LANES-1:0]   req_data,
   input  logic [LANES-1:0]     req_byte_en,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [8*LANES-1:0]   resp_data
);

   localparam int c_LG    = $clog2(LANES);
   localparam int c_ROW_W = ADDR_W - c_LG;
   localparam int c_ROWS  = 1 << c_ROW_W;
   localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(FIFO_DEPTH - 1);

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   logic [c_LG-1:0]    w_off;
   logic [c_ROW_W-1:0] w_row;
   logic [c_ROW_W-1:0] w_row_p1;
   logic               w_accept;
   logic               w_wr_acc;
   logic               w_rd_acc;

   assign w_off    = req_address[c_LG-1:0];
   assign w_row    = req_address[ADDR_W-1:c_LG];
   // Wraps modulo 2^ROW_W so an access at the top of memory continues at row 0
   assign w_row_p1 = w_row + c_ROW_W'(1);
   assign w_accept = req_valid && req_ready;
   assign w_wr_acc = w_accept && req_write;
   assign w_rd_acc = w_accept && !req_write;

   // Write data and enables rotated left by the byte offset so that request
   // byte j lands in lane (off + j) mod LANES.
   logic [8*LANES-1:0] w_wdata;
   logic [LANES-1:0]   w_we;

   always_comb begin
      w_wdata = '0;
      w_we    = '0;
      for (int i = 0; i < LANES; i++) begin
         w_wdata[8*i +: 8] = req_data[8*((i + LANES - int'(w_off)) % LANES) +: 8];
         w_we[i]           = req_byte_en[(i + LANES - int'(w_off)) % LANES] & w_wr_acc;
      end
   end

   // ---------------------------------------------------------------------
   // Byte banks
   // ---------------------------------------------------------------------
   logic [8*LANES-1:0] w_bank_q;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_bank
      logic [7:0]         r_mem [c_ROWS];
      logic [7:0]         r_q;
      logic [c_ROW_W-1:0] w_addr;

      // Lanes below the offset hold the tail of the access in the next row
      assign w_addr = (gi < int'(w_off)) ? w_row_p1 : w_row;

      always_ff @(posedge clock) begin
         if (w_we[gi]) begin
            r_mem[w_addr] <= w_wdata[8*gi +: 8];
         end
         if (w_rd_acc) begin
            r_q <= r_mem[w_addr];
         end
      end

      assign w_bank_q[8*gi +: 8] = r_q;
   end

   // ---------------------------------------------------------------------
   // Read pipeline: the offset travels alongside the bank data so the
   // final rotation never depends on the live request address.
   // ---------------------------------------------------------------------
   logic            r_v1;
   logic [c_LG-1:0] r_off1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_v1   <= 1'b0;
         r_off1 <= '0;
      end else begin
         r_v1 <= w_rd_acc;
         if (w_rd_acc) begin
            r_off1 <= w_off;
         end
      end
   end

   logic               w_pipe_v;
   logic [c_LG-1:0]    w_pipe_off;
   logic [8*LANES-1:0] w_pipe_q;

   if (OUT_REG != 0) begin : g_out_reg
      logic               r_v2;
      logic [c_LG-1:0]    r_off2;
      logic [8*LANES-1:0] r_q2;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            r_v2   <= 1'b0;
            r_off2 <= '0;
            r_q2   <= '0;
         end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_off2 <= r_off1;
               r_q2   <= w_bank_q;
            end
         end
      end

      assign w_pipe_v   = r_v2;
      assign w_pipe_off = r_off2;
      assign w_pipe_q   = r_q2;
   end else begin : g_no_out_reg
      assign w_pipe_v   = r_v1;
      assign w_pipe_off = r_off1;
      assign w_pipe_q   = w_bank_q;
   end

   // Aligned row data rotated right by the captured offset
   logic [8*LANES-1:0] w_pipe_rot;

   always_comb begin
      w_pipe_rot = '0;
      for (int j = 0; j < LANES; j++) begin
         w_pipe_rot[8*j +: 8] = w_pipe_q[8*((j + int'(w_pipe_off)) % LANES) +: 8];
      end
   end

   // ---------------------------------------------------------------------
   // Response FIFO (first-word-fall-through). When empty, the pipeline
   // output is presented directly; it is only stored if not taken at once.
   // ---------------------------------------------------------------------
   logic [8*LANES-1:0] r_fifo [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wptr;
   logic [c_PTR_W-1:0] r_rptr;
   logic [c_CNT_W-1:0] r_count;
   logic [c_CNT_W-1:0] r_outst;
   logic               r_rdy_en;

   logic               w_fifo_empty;
   logic               w_pop;
   logic               w_store;
   logic               w_fifo_pop;
   logic [8*LANES-1:0] w_head;

   assign w_fifo_empty = (r_count == '0);
   assign resp_valid   = !w_fifo_empty || w_pipe_v;
   assign w_head       = w_fifo_empty ? w_pipe_rot : r_fifo[r_rptr];
   assign resp_data    = resp_valid ? w_head : '0;
   assign w_pop        = resp_valid && resp_ready;
   assign w_store      = w_pipe_v && !(w_fifo_empty && resp_ready);
   assign w_fifo_pop   = w_pop && !w_fifo_empty;

   // Outstanding reads (in flight + queued) never exceed the FIFO depth
   assign req_ready    = r_rdy_en && (r_outst < c_DEPTH);

   always_ff @(posedge clock) begin
      if (w_store) begin
         r_fifo[r_wptr] <= w_pipe_rot;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_outst  <= '0;
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_store) begin
            r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + c_PTR_W'(1);
         end
         if (w_fifo_pop) begin
            r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + c_PTR_W'(1);
         end
         if (w_store && !w_fifo_pop) begin
            r_count <= r_count + c_CNT_W'(1);
         end else if (!w_store && w_fifo_pop) begin
            r_count <= r_count - c_CNT_W'(1);
         end
         if (w_rd_acc && !w_pop) begin
            r_outst <= r_outst + c_CNT_W'(1);
         end else if (!w_rd_acc && w_pop) begin
            r_outst <= r_outst - c_CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_unaligned_banked_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_unaligned_banked_pipe
// Purpose  : Directed self-checking bench for ram_unaligned_banked_pipe with
//            LANES=16, ADDR_W=20, OUT_REG=1, FIFO_DEPTH=3. Expected values
//            are hand-computed from the memory image built by the writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_unaligned_banked_pipe;

   logic         clock;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [19:0]  req_address;
   logic [127:0] req_data;
   logic [15:0]  req_byte_en;
   logic         resp_valid;
   logic         resp_ready;
   logic [127:0] resp_data;

   int checks = 0;
   int errors = 0;

   ram_unaligned_banked_pipe #(
      .LANES      (16),
      .ADDR_W     (20),
      .OUT_REG    (1),
      .FIFO_DEPTH (3),
      .INIT_FILE  ("")
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_address (req_address),
      .req_data    (req_data),
      .req_byte_en (req_byte_en),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   localparam logic [127:0] c_FULL = {128{1'b1}};

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents a request and returns #1 after the edge that accepted it
   task automatic issue(input logic wr, input logic [19:0] addr,
                        input logic [127:0] data, input logic [15:0] be);
      int n;
      req_valid   = 1'b1;
      req_write   = wr;
      req_address = addr;
      req_data    = data;
      req_byte_en = be;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      if (n == 20) check("req_accept_timeout", 128'(req_ready), 128'd1);
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   // Read with resp_ready=1; checks the 2-cycle latency and the masked data
   task automatic read_check(input string tag, input logic [19:0] addr,
                             input logic [127:0] exp, input logic [127:0] mask);
      int lat;
      issue(1'b0, addr, '0, '0);
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
      check({tag, "_latency"}, 128'(lat), 128'd2);
      check({tag, "_data"}, resp_data & mask, exp & mask);
      @(posedge clock); #1;
   endtask

   logic [19:0]  bp_addr [5];
   logic [127:0] bp_exp  [5];
   logic [127:0] bp_got  [5];

   initial begin
      int  idx;
      int  got;
      logic rdy;
      logic v;
      logic [127:0] d;

      bp_addr = '{20'h00020, 20'hFFFFA, 20'h00000, 20'h0000D, 20'h00008};
      bp_exp  = '{128'h0F0E0D0C0B0A09080706050403020100,
                  128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0,
                  128'h5F5E5D5C5B5ACFCECDCCCBCAC9C8C7C6,
                  128'hAFAEADACABAAA9A8A7A6A5A4A35F5E5D,
                  128'hAAA9A8A7A6A5A4A35F5E5D5C5B5ACFCE};

      reset       = 1'b0;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_address = '0;
      req_data    = '0;
      req_byte_en = '0;
      resp_ready  = 1'b1;

      // ---- reset state ----
      repeat (3) @(posedge clock);
      #1;
      check("rst_req_ready", 128'(req_ready), 128'd0);
      check("rst_resp_valid", 128'(resp_valid), 128'd0);
      check("rst_resp_data", resp_data, 128'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      check("post_rst_req_ready", 128'(req_ready), 128'd1);

      // ---- aligned write/read ----
      issue(1'b1, 20'h00020, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF);
      read_check("aligned", 20'h00020, 128'h0F0E0D0C0B0A09080706050403020100, c_FULL);

      // ---- unaligned row crossing ----
      issue(1'b1, 20'h0000D, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 16'hFFFF);
      read_check("unaligned", 20'h0000D, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, c_FULL);
      read_check("next_row", 20'h00010, 128'h000000AFAEADACABAAA9A8A7A6A5A4A3,
                 128'h000000FFFFFFFFFFFFFFFFFFFFFFFFFF);

      // ---- partial enables over a known background ----
      issue(1'b1, 20'h00000, 128'h5F5E5D5C5B5A59585756555453525150, 16'hFFFF);
      issue(1'b1, 20'h00005, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFF2211, 16'h0003);
      read_check("partial", 20'h00005, 128'hA7A6A5A4A35F5E5D5C5B5A5958572211, c_FULL);
      read_check("partial_row0", 20'h00000, 128'h5F5E5D5C5B5A59585722115453525150, c_FULL);

      // ---- top-of-memory wrap ----
      issue(1'b1, 20'hFFFFA, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0, 16'hFFFF);
      read_check("wrap_row0", 20'h00000, 128'h5F5E5D5C5B5ACFCECDCCCBCAC9C8C7C6, c_FULL);
      read_check("wrap_top", 20'hFFFFA, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0, c_FULL);

      // ---- backpressure: only FIFO_DEPTH reads accepted while stalled ----
      resp_ready  = 1'b0;
      idx         = 0;
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_address = bp_addr[0];
      for (int c = 0; c < 8; c++) begin
         rdy = req_ready && req_valid;
         @(posedge clock); #1;
         if (rdy) begin
            idx++;
            if (idx < 5) req_address = bp_addr[idx];
            else         req_valid   = 1'b0;
         end
      end
      check("bp_accepted", 128'(idx), 128'd3);
      check("bp_req_ready", 128'(req_ready), 128'd0);
      check("bp_resp_valid", 128'(resp_valid), 128'd1);
      check("bp_head", resp_data, bp_exp[0]);

      resp_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 5; c++) begin
         rdy = req_ready && req_valid;
         v   = resp_valid;
         d   = resp_data;
         @(posedge clock); #1;
         if (v) begin
            bp_got[got] = d;
            got++;
         end
         if (rdy) begin
            idx++;
            if (idx < 5) req_address = bp_addr[idx];
            else         req_valid   = 1'b0;
         end
      end
      check("bp_resp_count", 128'(got), 128'd5);
      for (int k = 0; k < got; k++) begin
         check($sformatf("bp_resp%0d", k), bp_got[k], bp_exp[k]);
      end
      repeat (3) @(posedge clock);
      #1;
      check("bp_no_dup", 128'(resp_valid), 128'd0);

      // ---- reset with reads in flight ----
      resp_ready  = 1'b0;
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_address = 20'h00020;
      @(posedge clock); #1;
      req_address = 20'h00000;
      @(posedge clock); #1;
      req_valid = 1'b0;
      check("mid_pre_valid", 128'(resp_valid), 128'd1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_valid", 128'(resp_valid), 128'd0);
      check("mid_rst_ready", 128'(req_ready), 128'd0);
      check("mid_rst_data", resp_data, 128'd0);
      @(posedge clock); #1;
      check("mid_rst_hold_valid", 128'(resp_valid), 128'd0);
      reset = 1'b1;
      resp_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("post_mid_valid", 128'(resp_valid), 128'd0);
      check("post_mid_ready", 128'(req_ready), 128'd1);
      read_check("after_rst_a", 20'h00020, bp_exp[0], c_FULL);
      read_check("after_rst_b", 20'h00000, bp_exp[2], c_FULL);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
